// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// State encoding, BCD digit width and the add-3 correction threshold.
package bin2bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Combinational double-dabble digit corrector: digits of 5 or more get +3
// so that the following left shift carries correctly into the next digit.
module bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    assign o_digit = (i_digit >= ADD3_THRESH) ? i_digit + BCD_DIGIT_W'(3) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock.
// Define BIN2BCD_BLANK_EN to add the registered leading-zero mask output "blank".
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                          CLOCK_50,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin_in,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
`ifdef BIN2BCD_BLANK_EN
    output logic [DIGITS-1:0]             blank,
`endif
    output logic [1:0]                    o_dbg_state
);

    localparam int SCR_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    // Handshake: start is a level sampled every cycle but only accepted in
    // IDLE or DONE; busy is high exactly in SHIFT, done is a one-cycle pulse
    // in DONE, and bcd_out only changes on the edge that enters DONE.

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_shift;
    logic [SCR_W-1:0]   r_scratch;
    logic [CNT_W-1:0]   r_count;
    logic [SCR_W-1:0]   r_bcd;
    logic [SCR_W-1:0]   w_corrected;
    logic [SCR_W-1:0]   w_scratch_next;
    logic               w_unused_carry;
    logic               w_last;
    logic               w_accept;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .i_digit(r_scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .o_digit(w_corrected[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // The bit shifted out of the scratch MSB is always zero for legal parameters.
    assign {w_unused_carry, w_scratch_next} = {w_corrected, r_shift[WIDTH-1]};
    assign w_last   = (r_count == CNT_W'(WIDTH - 1));
    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next_state = ST_SHIFT;
            ST_SHIFT: if (w_last) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = start ? ST_SHIFT : ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] r_blank;
    logic [DIGITS-1:0] w_blank_next;

    // Digit 0 is never blanked so that zero still shows a single "0".
    always_comb begin
        logic v_zero;
        w_blank_next = '0;
        v_zero       = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            v_zero          = v_zero && (w_scratch_next[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            w_blank_next[i] = v_zero;
        end
    end

    assign blank = r_blank;
`endif

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_count   <= '0;
            r_bcd     <= '0;
`ifdef BIN2BCD_BLANK_EN
            r_blank   <= '0;
`endif
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_shift   <= bin_in;
                r_scratch <= '0;
                r_count   <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_scratch <= w_scratch_next;
                r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
                r_count   <= r_count + CNT_W'(1);
                if (w_last) begin
                    r_bcd <= w_scratch_next;
`ifdef BIN2BCD_BLANK_EN
                    r_blank <= w_blank_next;
`endif
                end
            end
        end
    end

    assign busy        = (r_state == ST_SHIFT);
    assign done        = (r_state == ST_DONE);
    assign bcd_out     = r_bcd;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed scenarios plus random start
// traffic, checked every cycle against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int BW     = 4 * DIGITS;

    logic              CLOCK_50;
    logic              rst_n;
    logic              start;
    logic [WIDTH-1:0]  bin_in;
    logic              busy;
    logic              done;
    logic [BW-1:0]     bcd_out;
    logic [DIGITS-1:0] blank;
    logic [1:0]        o_dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    bit mon_en   = 0;

    // Reference model state: cycles since the accepted start (0 = none).
    int               m_phase = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [BW-1:0]    m_bcd   = '0;
    logic [DIGITS-1:0] m_blank = '0;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .CLOCK_50    (CLOCK_50),
        .rst_n       (rst_n),
        .start       (start),
        .bin_in      (bin_in),
        .busy        (busy),
        .done        (done),
        .bcd_out     (bcd_out),
`ifdef BIN2BCD_BLANK_EN
        .blank       (blank),
`endif
        .o_dbg_state (o_dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        CLOCK_50 = 1'b0;
        forever #10 CLOCK_50 = ~CLOCK_50;
    end

    // ---------------- reference arithmetic ----------------
    function automatic logic [BW-1:0] bcd_of(input int v);
        logic [BW-1:0] r;
        int rem;
        r   = '0;
        rem = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] blank_of(input int v);
        logic [DIGITS-1:0] b;
        int lim;
        b   = '0;
        lim = 10;
        for (int i = 1; i < DIGITS; i++) begin
            b[i] = (v < lim);
            lim  = lim * 10;
        end
        return b;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    always @(posedge CLOCK_50) begin
        if (!rst_n) begin
            m_phase = 0;
            exp_q.delete();
            m_bcd   = '0;
            m_blank = '0;
        end else if (start && (m_phase == 0 || m_phase == WIDTH + 1)) begin
            exp_q.push_back(bin_in);
            m_phase = 1;
        end else if (m_phase >= 1 && m_phase <= WIDTH) begin
            m_phase++;
            if (m_phase == WIDTH + 1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL model_queue: empty at completion at %0t", $time);
                end else begin
                    logic [WIDTH-1:0] v;
                    v       = exp_q.pop_front();
                    m_bcd   = bcd_of(int'(v));
                    m_blank = blank_of(int'(v));
                end
            end
        end else begin
            m_phase = 0;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    always @(negedge CLOCK_50) begin
        if (done) n_done++;
        if (mon_en) begin
            check_eq("busy", busy, (m_phase >= 1 && m_phase <= WIDTH));
            check_eq("done", done, (m_phase == WIDTH + 1));
            check_eq("bcd_out", bcd_out, m_bcd);
`ifdef BIN2BCD_BLANK_EN
            check_eq("blank", blank, m_blank);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [WIDTH-1:0] v);
        @(negedge CLOCK_50);
        start  = 1'b1;
        bin_in = v;
        @(negedge CLOCK_50);
        start  = 1'b0;
        bin_in = WIDTH'($urandom);
    endtask

    task automatic wait_done(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(negedge CLOCK_50);
            cycles++;
        end while (!done && cycles < 40);
        if (!done) check_eq({tag, "_timeout"}, done, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c;
        int n0;
        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;

        repeat (3) @(negedge CLOCK_50);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_bcd", bcd_out, 0);
        check_eq("rst_state", o_dbg_state, 0);
`ifdef BIN2BCD_BLANK_EN
        check_eq("rst_blank", blank, 0);
`endif
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // zero
        do_start(8'd0);
        wait_done("zero", c);
        check_eq("zero_latency", c, WIDTH);
        check_eq("zero_bcd", bcd_out, 12'h000);
`ifdef BIN2BCD_BLANK_EN
        check_eq("zero_blank", blank, 3'b110);
`endif

        // maximum
        do_start(8'd255);
        wait_done("max", c);
        check_eq("max_latency", c, WIDTH);
        check_eq("max_bcd", bcd_out, 12'h255);
`ifdef BIN2BCD_BLANK_EN
        check_eq("max_blank", blank, 3'b000);
`endif

        // 7 then 99; the monitor checks bcd_out holds 007 meanwhile
        do_start(8'd7);
        wait_done("seven", c);
        check_eq("seven_bcd", bcd_out, 12'h007);
`ifdef BIN2BCD_BLANK_EN
        check_eq("seven_blank", blank, 3'b110);
`endif
        do_start(8'd99);
        check_eq("hold_bcd", bcd_out, 12'h007);
        wait_done("ninety_nine", c);
        check_eq("ninety_nine_bcd", bcd_out, 12'h099);
`ifdef BIN2BCD_BLANK_EN
        check_eq("ninety_nine_blank", blank, 3'b100);
`endif

        // start during busy is ignored
        do_start(8'd200);
        repeat (3) @(negedge CLOCK_50);
        n0     = n_done;
        start  = 1'b1;
        bin_in = 8'd13;
        @(negedge CLOCK_50);
        start  = 1'b0;
        wait_done("ignore", c);
        check_eq("ignore_latency", c, 4);
        repeat (12) @(negedge CLOCK_50);
        check_eq("ignore_bcd", bcd_out, 12'h200);
        check_eq("ignore_one_done", n_done - n0, 1);

        // back-to-back with start held high
        @(negedge CLOCK_50);
        start  = 1'b1;
        bin_in = 8'd128;
        for (int k = 0; k < 3; k++) begin
            wait_done("b2b", c);
            check_eq("b2b_period", c, WIDTH + 1);
            check_eq("b2b_bcd", bcd_out, 12'h128);
        end
        start = 1'b0;
        repeat (12) @(negedge CLOCK_50);

        // reset aborts a conversion
        do_start(8'd255);
        repeat (4) @(negedge CLOCK_50);
        rst_n = 1'b0;
        @(negedge CLOCK_50);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_bcd", bcd_out, 0);
        rst_n = 1'b1;
        n0    = n_done;
        repeat (15) @(negedge CLOCK_50);
        check_eq("abort_no_done", n_done - n0, 0);
        do_start(8'd42);
        wait_done("after_abort", c);
        check_eq("after_abort_bcd", bcd_out, 12'h042);

        // random start traffic, including starts while busy
        for (int k = 0; k < 400; k++) begin
            @(negedge CLOCK_50);
            start  = ($urandom_range(0, 3) == 0);
            bin_in = WIDTH'($urandom);
        end
        @(negedge CLOCK_50);
        start = 1'b0;
        repeat (12) @(negedge CLOCK_50);
        check_eq("drain_queue", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
